// File: rtl/flash_loader.sv
// Boot-time copier: streams bytes out of an SPI flash with a plain READ (0x03) command
// and writes them as little-endian 32-bit words into RAM through the ramio write port.
// done rises once the whole image is in RAM and stays high until reset.
module flash_loader #(
  parameter int unsigned StartupWaitCycles      = 500_000,
  parameter int unsigned FlashTransferByteCount = 4096,
  parameter logic [23:0] FlashStartAddress      = 24'h0,
  parameter logic [31:0] RamStartAddress        = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        flash_clk,
  input  logic        flash_miso,
  output logic        flash_mosi,
  output logic        flash_cs_n,
  output logic        ramio_enable,
  output logic [1:0]  ramio_write_type,
  output logic [31:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic        ramio_busy,
  output logic        done
);

  localparam int unsigned WordCount = FlashTransferByteCount / 4;
  localparam int unsigned WordW     = (WordCount > 1) ? $clog2(WordCount) : 1;
  localparam int unsigned StartW    = (StartupWaitCycles > 0) ? $clog2(StartupWaitCycles + 1) : 1;
  localparam int unsigned BitW      = $clog2(32);

  localparam logic [StartW-1:0] StartLast = StartW'(StartupWaitCycles);
  localparam logic [WordW-1:0]  WordLast  = WordW'(WordCount - 1);
  // Command byte followed by the 24-bit address, sent as one 32-bit MSB-first stream.
  localparam logic [31:0]       Header    = {8'h03, FlashStartAddress};

  typedef enum logic [2:0] {
    StStartup,
    StSendCmd,
    StSendAddr,
    StReadWord,
    StWriteRam,
    StWaitRam,
    StDone
  } state_e;

  state_e            state_q;
  logic [StartW-1:0] start_cnt_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [WordW-1:0]  word_cnt_q;
  logic              phase_q;
  logic [31:0]       tx_q;
  logic [31:0]       rx_q;

  logic [31:0] rx_next;
  logic [31:0] word_le;

  // Flash bytes arrive MSB first; the first byte of a word ends up in the top byte of
  // rx_next and is swapped down to [7:0] for the little-endian RAM image.
  assign rx_next = {rx_q[30:0], flash_miso};
  assign word_le = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};

  // Copy sequencer: SPI bit engine, RAM handshake and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StStartup;
      start_cnt_q      <= '0;
      bit_cnt_q        <= '0;
      word_cnt_q       <= '0;
      phase_q          <= 1'b0;
      tx_q             <= '0;
      rx_q             <= '0;
      flash_cs_n       <= 1'b1;
      flash_clk        <= 1'b0;
      flash_mosi       <= 1'b0;
      ramio_enable     <= 1'b0;
      ramio_write_type <= 2'b00;
      ramio_address    <= RamStartAddress;
      ramio_data_in    <= '0;
      done             <= 1'b0;
    end else begin
      unique case (state_q)
        StStartup: begin
          if (start_cnt_q == StartLast) begin
            state_q    <= StSendCmd;
            flash_cs_n <= 1'b0;
            tx_q       <= Header;
            flash_mosi <= Header[31];
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
          end else begin
            start_cnt_q <= start_cnt_q + StartW'(1);
          end
        end

        StSendCmd, StSendAddr, StReadWord: begin
          if (!phase_q) begin
            flash_clk <= 1'b1;
            phase_q   <= 1'b1;
          end else begin
            // End of high phase: sample miso, drop the clock, present the next bit.
            flash_clk  <= 1'b0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= bit_cnt_q + BitW'(1);
            tx_q       <= {tx_q[30:0], 1'b0};
            flash_mosi <= tx_q[30];
            if (state_q == StSendCmd) begin
              if (bit_cnt_q == BitW'(7)) begin
                state_q   <= StSendAddr;
                bit_cnt_q <= '0;
              end
            end else if (state_q == StSendAddr) begin
              if (bit_cnt_q == BitW'(23)) begin
                state_q    <= StReadWord;
                bit_cnt_q  <= '0;
                flash_mosi <= 1'b0;
              end
            end else begin
              flash_mosi <= 1'b0;
              rx_q       <= rx_next;
              if (bit_cnt_q == BitW'(31)) begin
                state_q       <= StWriteRam;
                bit_cnt_q     <= '0;
                ramio_data_in <= word_le;
              end
            end
          end
        end

        StWriteRam: begin
          if (!ramio_busy) begin
            ramio_enable     <= 1'b1;
            ramio_write_type <= 2'b11;
            state_q          <= StWaitRam;
          end
        end

        StWaitRam: begin
          ramio_enable     <= 1'b0;
          ramio_write_type <= 2'b00;
          if (!ramio_busy) begin
            ramio_address <= ramio_address + 32'd4;
            if (word_cnt_q == WordLast) begin
              state_q    <= StDone;
              flash_cs_n <= 1'b1;
              flash_clk  <= 1'b0;
            end else begin
              // cs_n stays low so the flash keeps streaming from where it paused.
              word_cnt_q <= word_cnt_q + WordW'(1);
              state_q    <= StReadWord;
              phase_q    <= 1'b0;
            end
          end
        end

        StDone: begin
          done <= 1'b1;
        end

        default: begin
          state_q <= StStartup;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Bench for flash_loader: behavioural SPI flash, randomly stalling RAM port, and a
// scoreboard of expected RAM writes checked by an independent monitor.
module tb_flash_loader;

  localparam int unsigned ByteCount = 256;
  localparam int unsigned Words     = ByteCount / 4;
  localparam logic [23:0] FlashBase = 24'h000020;
  localparam logic [31:0] RamBase   = 32'h0000_0200;
  localparam int          FlashSize = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // Main DUT (no startup wait)
  logic        flash_clk, flash_miso, flash_mosi, flash_cs_n;
  logic        ramio_enable, ramio_busy, done;
  logic [1:0]  ramio_write_type;
  logic [31:0] ramio_address, ramio_data_in;
  // Second DUT (startup wait of 5, one word)
  logic        b_flash_clk, b_flash_mosi, b_flash_cs_n, b_ramio_enable, b_done;
  logic [1:0]  b_ramio_write_type;
  logic [31:0] b_ramio_address, b_ramio_data_in;

  flash_loader #(
    .StartupWaitCycles     (0),
    .FlashTransferByteCount(ByteCount),
    .FlashStartAddress     (FlashBase),
    .RamStartAddress       (RamBase)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flash_clk       (flash_clk),
    .flash_miso      (flash_miso),
    .flash_mosi      (flash_mosi),
    .flash_cs_n      (flash_cs_n),
    .ramio_enable    (ramio_enable),
    .ramio_write_type(ramio_write_type),
    .ramio_address   (ramio_address),
    .ramio_data_in   (ramio_data_in),
    .ramio_busy      (ramio_busy),
    .done            (done)
  );

  flash_loader #(
    .StartupWaitCycles     (5),
    .FlashTransferByteCount(4),
    .FlashStartAddress     (24'h0),
    .RamStartAddress       (32'h0)
  ) u_dut_wait (
    .clk             (clk),
    .rst_n           (rst_n),
    .flash_clk       (b_flash_clk),
    .flash_miso      (1'b0),
    .flash_mosi      (b_flash_mosi),
    .flash_cs_n      (b_flash_cs_n),
    .ramio_enable    (b_ramio_enable),
    .ramio_write_type(b_ramio_write_type),
    .ramio_address   (b_ramio_address),
    .ramio_data_in   (b_ramio_data_in),
    .ramio_busy      (1'b0),
    .done            (b_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- behavioural SPI flash ----------------
  logic [7:0]  fmem [FlashSize];
  logic [31:0] hdr = '0;
  int          fn = 0;
  int          mosi_err = 0;

  always @(negedge flash_cs_n) fn = 0;

  always @(posedge flash_clk) begin
    if (!flash_cs_n) begin
      if (fn < 32) hdr = {hdr[30:0], flash_mosi};
      else if (flash_mosi !== 1'b0) mosi_err++;
      fn++;
    end
  end

  // Data bit j is presented after the falling edge that follows clock rise 32+j.
  always @(negedge flash_clk) begin
    if (!flash_cs_n && fn >= 32) begin
      int j;
      int idx;
      logic [7:0] b;
      j   = fn - 32;
      idx = (int'(hdr[23:0]) + j / 8) % FlashSize;
      b   = fmem[idx];
      flash_miso = b[7 - (j % 8)];
    end
  end

  // ---------------- RAM side: stall generator ----------------
  logic busy_rand = 1'b0;
  int   burst = 0;
  logic last_busy = 1'b0;

  always @(negedge clk) begin
    if (!busy_rand) begin
      ramio_busy = 1'b0;
    end else if (burst > 0) begin
      ramio_busy = 1'b1;
      burst--;
    end else if ($urandom_range(0, 7) == 0) begin
      ramio_busy = 1'b1;
      burst = 9;
    end else begin
      ramio_busy = ($urandom_range(0, 3) == 0);
    end
  end

  always @(posedge clk) last_busy = ramio_busy;

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t  sb[$];
  int   pulses = 0;
  int   proto_err = 0;
  logic prev_en = 1'b0;

  task automatic push_expected();
    for (int w = 0; w < int'(Words); w++) begin
      wr_t e;
      e.addr = RamBase + 32'(4 * w);
      for (int k = 0; k < 4; k++)
        e.data[8*k +: 8] = fmem[(int'(FlashBase) + 4 * w + k) % FlashSize];
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ramio_enable) begin
        pulses++;
        if (last_busy) proto_err++;
        if (prev_en) proto_err++;
        if (flash_clk) proto_err++;
        if (sb.size() == 0) begin
          check("unexpected_write", ramio_address, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", ramio_address, e.addr);
          check("wr_data", ramio_data_in, e.data);
          check("wr_type", {30'd0, ramio_write_type}, 32'd3);
        end
      end else if (ramio_write_type !== 2'b00) begin
        proto_err++;
      end
      prev_en = ramio_enable;
    end else begin
      prev_en = 1'b0;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic fill_flash();
    for (int i = 0; i < FlashSize; i++) fmem[i] = 8'($urandom);
  endtask

  task automatic check_reset_outputs();
    check("rst_cs_n", {31'd0, flash_cs_n}, 32'd1);
    check("rst_flash_clk", {31'd0, flash_clk}, 32'd0);
    check("rst_mosi", {31'd0, flash_mosi}, 32'd0);
    check("rst_enable", {31'd0, ramio_enable}, 32'd0);
    check("rst_type", {30'd0, ramio_write_type}, 32'd0);
    check("rst_addr", ramio_address, RamBase);
    check("rst_data", ramio_data_in, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
  endtask

  // Release reset and count clock edges until each chip select falls.
  task automatic release_and_check_startup();
    int fall_a = 0;
    int fall_b = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (fall_a == 0 && flash_cs_n === 1'b0) fall_a = e;
      if (fall_b == 0 && b_flash_cs_n === 1'b0) fall_b = e;
    end
    check("cs_fall_edge_nowait", 32'(fall_a), 32'd1);
    check("cs_fall_edge_wait5", 32'(fall_b), 32'd6);
  endtask

  task automatic finish_run(input string tag);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_in_time"}, {31'd0, done}, 32'd1);
    repeat (20) @(negedge clk);
    check({tag, "_done_sticky"}, {31'd0, done}, 32'd1);
    check({tag, "_cs_n_end"}, {31'd0, flash_cs_n}, 32'd1);
    check({tag, "_flash_clk_end"}, {31'd0, flash_clk}, 32'd0);
    check({tag, "_final_addr"}, ramio_address, RamBase + 32'(4 * Words));
    check({tag, "_pulses"}, 32'(pulses), 32'(Words));
    check({tag, "_left_in_sb"}, 32'(sb.size()), 32'd0);
    check({tag, "_cmd_addr"}, hdr, {8'h03, FlashBase});
    check({tag, "_mosi_during_read"}, 32'(mosi_err), 32'd0);
    check({tag, "_protocol"}, 32'(proto_err), 32'd0);
  endtask

  task automatic clear_run_state();
    sb.delete();
    pulses    = 0;
    proto_err = 0;
    mosi_err  = 0;
  endtask

  initial begin
    rst_n      = 1'b0;
    ramio_busy = 1'b0;
    flash_miso = 1'b0;

    // Run 1: fixed first eight bytes, random remainder, random RAM stalls.
    fill_flash();
    begin
      logic [7:0] pre [8];
      pre = '{8'h37, 8'h01, 8'h01, 8'h00, 8'hef, 8'h00, 8'h40, 8'h00};
      for (int i = 0; i < 8; i++) fmem[int'(FlashBase) + i] = pre[i];
    end
    clear_run_state();
    push_expected();
    check("sb_word0", sb[0].data, 32'h0001_0137);
    check("sb_word1", sb[1].data, 32'h0040_00ef);
    repeat (3) @(negedge clk);
    check_reset_outputs();
    release_and_check_startup();
    busy_rand = 1'b1;
    finish_run("run1");
    check("wait5_done", {31'd0, b_done}, 32'd1);
    check("wait5_addr", b_ramio_address, 32'd4);

    // Run 2: restart, abort mid-read with an asynchronous reset, then a full copy.
    busy_rand = 1'b0;
    rst_n = 1'b0;
    fill_flash();
    clear_run_state();
    push_expected();
    repeat (2) @(negedge clk);
    release_and_check_startup();
    begin
      int cyc = 0;
      while (pulses < 3 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      check("run2_pre_reset_pulses", {31'd0, pulses >= 3}, 32'd1);
    end
    repeat (12) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    fill_flash();
    clear_run_state();
    push_expected();
    repeat (2) @(negedge clk);
    release_and_check_startup();
    busy_rand = 1'b1;
    finish_run("run2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
